word_tx_serializer: RTL and testbench



---
 rtl/word_tx_serializer_pkg.sv | 30 +++
 rtl/word_tx_serializer_if.sv | 30 +++
 rtl/word_tx_serializer_byte_shift_reg.sv | 41 ++++
 rtl/word_tx_serializer.sv | 125 ++++++++++++
 tb/tb_word_tx_serializer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/word_tx_serializer_pkg.sv
// Shared definitions for the word serializer and its receive-side word assembler:
// geometry defaults, state encoding and byte order.
package word_tx_serializer_pkg;

    localparam int NB_DATA = 32;
    localparam int N_BITS  = 8;
    localparam int N_BYTES = NB_DATA / N_BITS;
    localparam int NB_ADDR = 7;

    // Raw 3-bit state codes, kept visible so other blocks and debug tools can decode them.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_LOAD      = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        FETCH     = ST_FETCH,
        LOAD      = ST_LOAD,
        SEND      = ST_SEND,
        WAIT_DONE = ST_WAIT_DONE,
        DONE      = ST_DONE
    } state_t;

    // Byte 0 on the wire is data[7:0]; the receiver reassembles in the same order.
    localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/word_tx_serializer_if.sv
// Bus bundle between the serializer, the debug unit, the word source and tx_uart.
// master = serializer side, slave = environment side.
interface word_tx_serializer_if #(
    parameter int NB_DATA = 32,
    parameter int N_BITS  = 8,
    parameter int NB_ADDR = 7
) ();

    logic               start_i;
    logic [NB_ADDR:0]   n_words_i;
    logic               rd_en_o;
    logic [NB_ADDR-1:0] addr_o;
    logic [NB_DATA-1:0] data_i;
    logic               tx_start_o;
    logic [N_BITS-1:0]  tx_data_o;
    logic               tx_done_tick_i;
    logic               busy_o;
    logic               finish_send_o;

    modport master (
        input  start_i, n_words_i, data_i, tx_done_tick_i,
        output rd_en_o, addr_o, tx_start_o, tx_data_o, busy_o, finish_send_o
    );

    modport slave (
        output start_i, n_words_i, data_i, tx_done_tick_i,
        input  rd_en_o, addr_o, tx_start_o, tx_data_o, busy_o, finish_send_o
    );

endinterface

// File: rtl/word_tx_serializer_byte_shift_reg.sv
// Word holding register that presents one byte at a time and tracks which byte is current.
module byte_shift_reg
    import word_tx_serializer_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int N_BITS  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [NB_DATA-1:0] data_in,
    output logic [N_BITS-1:0]  byte_out,
    output logic               last_byte
);

    localparam int NBYTES = NB_DATA / N_BITS;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [NB_DATA-1:0] sr;
    logic [IDX_W-1:0]   idx;

    // Load a fresh word or advance to the next byte; load has priority.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            sr  <= data_in;
            idx <= '0;
        end else if (shift) begin
            sr  <= LSB_FIRST ? (sr >> N_BITS) : (sr << N_BITS);
            idx <= idx + 1'b1;
        end
    end

    assign byte_out  = LSB_FIRST ? sr[N_BITS-1:0] : sr[NB_DATA-1 -: N_BITS];
    assign last_byte = (idx == IDX_W'(NBYTES - 1));

endmodule

// File: rtl/word_tx_serializer.sv
// Reads a run of words from a word-addressed source and feeds them byte by byte
// to tx_uart through its start/done handshake.
module word_tx_serializer
    import word_tx_serializer_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int N_BITS  = 8,
    parameter int NB_ADDR = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    word_tx_serializer_if.master   bus
);

    // Largest run that fits the address space; larger requests are clamped so addr never wraps.
    localparam logic [NB_ADDR:0] MAX_WORDS = {1'b1, {NB_ADDR{1'b0}}};

    state_t             state;
    state_t             next_state;
    logic [NB_ADDR:0]   count;
    logic [NB_ADDR-1:0] word_idx;
    logic [NB_ADDR:0]   count_in;
    logic               last_word;
    logic               last_byte;
    logic               load;
    logic               shift;
    logic               next_word;
    logic               rd_en;
    logic               tx_start;
    logic               finish;

    assign count_in  = (bus.n_words_i > MAX_WORDS) ? MAX_WORDS : bus.n_words_i;
    assign last_word = ({1'b0, word_idx} == (count - 1'b1));

    byte_shift_reg #(
        .NB_DATA (NB_DATA),
        .N_BITS  (N_BITS)
    ) u_shift (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .data_in   (bus.data_i),
        .byte_out  (bus.tx_data_o),
        .last_byte (last_byte)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-state strobes; done ticks only matter in WAIT_DONE.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        next_word  = 1'b0;
        tx_start   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    next_state = (count_in == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                rd_en      = 1'b1;
                next_state = LOAD;
            end
            LOAD: begin
                load       = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                tx_start   = 1'b1;
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_done_tick_i) begin
                    if (!last_byte) begin
                        shift      = 1'b1;
                        next_state = SEND;
                    end else if (!last_word) begin
                        next_word  = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Run length and word pointer: captured on an accepted start, advanced after each word's last byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            word_idx <= '0;
        end else if (state == IDLE && bus.start_i) begin
            count    <= count_in;
            word_idx <= '0;
        end else if (next_word) begin
            word_idx <= word_idx + 1'b1;
        end
    end

    assign bus.rd_en_o       = rd_en;
    assign bus.addr_o        = word_idx;
    assign bus.tx_start_o    = tx_start;
    assign bus.busy_o        = (state != IDLE);
    assign bus.finish_send_o = finish;

endmodule

// File: tb/tb_word_tx_serializer.sv
// Directed bench for word_tx_serializer: word source model, tx_uart responder
// with programmable done delay, and a negedge monitor logging bus activity.
module tb_word_tx_serializer;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    word_tx_serializer_if #(.NB_DATA(32), .N_BITS(8), .NB_ADDR(7)) bus ();

    word_tx_serializer #(.NB_DATA(32), .N_BITS(8), .NB_ADDR(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Word source: data valid one cycle after the read strobe.
    logic [31:0] mem [128];
    always @(posedge clock) begin
        if (bus.rd_en_o) bus.data_i <= mem[bus.addr_o];
    end

    // tx_uart responder: done tick done_delay cycles after each start, checking the byte holds.
    logic uart_tick     = 1'b0;
    logic spurious_tick = 1'b0;
    int   done_delay    = 10;
    int   hold_err      = 0;
    assign bus.tx_done_tick_i = uart_tick | spurious_tick;

    initial begin
        logic [7:0] b;
        bit         aborted;
        forever begin
            @(negedge clock);
            if (bus.tx_start_o && !reset) begin
                b       = bus.tx_data_o;
                aborted = 1'b0;
                for (int i = 0; i < done_delay; i++) begin
                    @(negedge clock);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (bus.tx_start_o || bus.tx_data_o !== b) hold_err++;
                end
                if (!aborted) begin
                    @(posedge clock);
                    #1 uart_tick = 1'b1;
                    @(posedge clock);
                    #1 uart_tick = 1'b0;
                end
            end
        end
    end

    // Bus monitor.
    int         cyc       = 0;
    int         tick_cyc  = 0;
    bit         tick_seen = 1'b0;
    int         fin_cnt   = 0;
    logic [7:0] byte_q [$];
    logic [6:0] addr_q [$];
    int         gap_q  [$];

    always @(negedge clock) begin
        if (bus.rd_en_o) addr_q.push_back(bus.addr_o);
        if (bus.tx_start_o) begin
            byte_q.push_back(bus.tx_data_o);
            if (tick_seen) gap_q.push_back(cyc - tick_cyc);
        end
        if (bus.finish_send_o) fin_cnt <= fin_cnt + 1;
        if (reset || bus.finish_send_o || bus.tx_start_o) tick_seen <= 1'b0;
        else if (uart_tick) begin
            tick_seen <= 1'b1;
            tick_cyc  <= cyc;
        end
        cyc <= cyc + 1;
    end

    function automatic logic [31:0] out_vec();
        return 32'({bus.rd_en_o, bus.addr_o, bus.tx_start_o, bus.tx_data_o,
                    bus.busy_o, bus.finish_send_o});
    endfunction

    task automatic run_start(input logic [7:0] n);
        @(negedge clock);
        bus.start_i   = 1'b1;
        bus.n_words_i = n;
        @(negedge clock);
        bus.start_i   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.busy_o && n < max_cycles);
        check({tag, "_idle_timeout"}, 32'(bus.busy_o), 32'd0);
    endtask

    task automatic check_word(input string tag, input int base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            if (base + i < byte_q.size()) check(tag, 32'(byte_q[base + i]), 32'(w[8*i +: 8]));
            else check({tag, "_missing"}, 32'(byte_q.size()), 32'(base + i + 1));
        end
    endtask

    initial begin
        int bb, ab, fb, gb, he, lat, fin_k, rd_seen, ts_seen, mism, n;
        logic [7:0] exp4  [4]  = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        logic [7:0] exp12 [12] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                   8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int         expgap[11] = '{1, 1, 1, 3, 1, 1, 1, 3, 1, 1, 1};

        bus.start_i   = 1'b0;
        bus.n_words_i = '0;

        // Reset state.
        repeat (3) @(negedge clock);
        check("reset_outputs", out_vec(), 32'd0);

        // start_i together with reset is dropped.
        bus.start_i   = 1'b1;
        bus.n_words_i = 8'd1;
        @(negedge clock);
        reset       = 1'b0;
        bus.start_i = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_wins_start_busy", 32'(bus.busy_o), 32'd0);
        check("reset_wins_start_rd", 32'(addr_q.size()), 32'd0);

        // Single word, done tick 10 cycles after each start.
        mem[0]     = 32'hA1B2C3D4;
        done_delay = 10;
        bb = byte_q.size(); fb = fin_cnt;
        @(negedge clock);
        bus.start_i   = 1'b1;
        bus.n_words_i = 8'd1;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus.start_i = 1'b0;
                check("single_fetch_rd_en", 32'(bus.rd_en_o), 32'd1);
                check("single_fetch_addr", 32'(bus.addr_o), 32'd0);
            end
            if (bus.tx_start_o) lat = k;
        end
        check("first_start_latency", 32'(lat), 32'd3);
        wait_idle(200, "single");
        check("single_start_pulses", 32'(byte_q.size() - bb), 32'd4);
        for (int i = 0; i < 4 && bb + i < byte_q.size(); i++)
            check("single_byte", 32'(byte_q[bb + i]), 32'(exp4[i]));
        check("single_finish_pulses", 32'(fin_cnt - fb), 32'd1);
        check("single_busy_after", 32'(bus.busy_o), 32'd0);

        // Three words, short done delay; also byte and word gaps.
        mem[0] = 32'h00000001; mem[1] = 32'h80000000; mem[2] = 32'hDEADBEEF;
        done_delay = 2;
        bb = byte_q.size(); ab = addr_q.size(); fb = fin_cnt; gb = gap_q.size();
        run_start(8'd3);
        wait_idle(500, "multi");
        check("multi_nbytes", 32'(byte_q.size() - bb), 32'd12);
        for (int i = 0; i < 12 && bb + i < byte_q.size(); i++)
            check("multi_byte", 32'(byte_q[bb + i]), 32'(exp12[i]));
        check("multi_rd_cycles", 32'(addr_q.size() - ab), 32'd3);
        for (int i = 0; i < 3 && ab + i < addr_q.size(); i++)
            check("multi_addr", 32'(addr_q[ab + i]), 32'(i));
        check("multi_ngaps", 32'(gap_q.size() - gb), 32'd11);
        for (int i = 0; i < 11 && gb + i < gap_q.size(); i++)
            check("multi_gap", 32'(gap_q[gb + i]), 32'(expgap[i]));
        check("multi_finish_pulses", 32'(fin_cnt - fb), 32'd1);

        // Zero count: straight to DONE, nothing read or sent.
        fb = fin_cnt;
        fin_k = -1; rd_seen = 0; ts_seen = 0;
        @(negedge clock);
        bus.start_i   = 1'b1;
        bus.n_words_i = 8'd0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 1) bus.start_i = 1'b0;
            if (bus.finish_send_o && fin_k < 0) fin_k = k;
            if (bus.rd_en_o) rd_seen++;
            if (bus.tx_start_o) ts_seen++;
        end
        check("zero_finish_window", 32'(fin_k >= 1 && fin_k <= 2), 32'd1);
        check("zero_finish_pulses", 32'(fin_cnt - fb), 32'd1);
        check("zero_rd_en", 32'(rd_seen), 32'd0);
        check("zero_tx_start", 32'(ts_seen), 32'd0);
        check("zero_busy_after", 32'(bus.busy_o), 32'd0);

        // Clamp 200 -> 128 words; restart request and spurious ticks mid-transfer.
        for (int i = 0; i < 128; i++)
            mem[i] = {8'(i), 8'(i ^ 8'h5A), 8'(~i), 8'(i + 3)};
        done_delay = 0;
        bb = byte_q.size(); ab = addr_q.size(); fb = fin_cnt;
        run_start(8'd200);
        repeat (40) @(negedge clock);
        bus.start_i   = 1'b1;
        bus.n_words_i = 8'd5;
        repeat (3) @(negedge clock);
        bus.start_i = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.rd_en_o && n < 100);
        check("clamp_rd_seen", 32'(bus.rd_en_o), 32'd1);
        spurious_tick = 1'b1;
        repeat (2) @(negedge clock);
        spurious_tick = 1'b0;
        wait_idle(20000, "clamp");
        check("clamp_nbytes", 32'(byte_q.size() - bb), 32'd512);
        check("clamp_rd_cycles", 32'(addr_q.size() - ab), 32'd128);
        mism = 0;
        for (int w = 0; w < 128; w++) begin
            if (ab + w < addr_q.size() && addr_q[ab + w] != 7'(w)) mism++;
            for (int j = 0; j < 4; j++)
                if (bb + 4*w + j < byte_q.size() && byte_q[bb + 4*w + j] != mem[w][8*j +: 8]) mism++;
        end
        check("clamp_data_mismatches", 32'(mism), 32'd0);
        check("clamp_last_addr", 32'(addr_q[addr_q.size() - 1]), 32'd127);
        check("clamp_finish_pulses", 32'(fin_cnt - fb), 32'd1);
        ab = addr_q.size();
        repeat (5) @(negedge clock);
        check("clamp_no_requeue", 32'(addr_q.size() - ab), 32'd0);

        // Reset after the 2nd byte of word 1, then a clean restart.
        mem[0] = 32'h03020100; mem[1] = 32'h07060504;
        done_delay = 4;
        bb = byte_q.size(); fb = fin_cnt;
        run_start(8'd2);
        n = 0;
        do begin
            @(posedge clock);
            n++;
        end while (byte_q.size() < bb + 6 && n < 500);
        check("reset_mid_reached", 32'(byte_q.size() - bb), 32'd6);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reset_mid_outputs", out_vec(), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("reset_mid_no_finish", 32'(fin_cnt - fb), 32'd0);
        check("reset_mid_busy", 32'(bus.busy_o), 32'd0);
        mem[0] = 32'h11223344;
        done_delay = 1;
        bb = byte_q.size(); ab = addr_q.size();
        run_start(8'd1);
        wait_idle(200, "restart");
        check("restart_rd_cycles", 32'(addr_q.size() - ab), 32'd1);
        if (ab < addr_q.size()) check("restart_addr", 32'(addr_q[ab]), 32'd0);
        check_word("restart_byte", bb, 32'h11223344);

        // Long handshake wait: byte must hold and no extra start.
        mem[0] = 32'hCAFE5A0F;
        done_delay = 1000;
        bb = byte_q.size(); he = hold_err;
        run_start(8'd1);
        wait_idle(6000, "hold");
        check("hold_violations", 32'(hold_err - he), 32'd0);
        check("hold_nbytes", 32'(byte_q.size() - bb), 32'd4);
        check_word("hold_byte", bb, 32'hCAFE5A0F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
